// File: rtl/memory_stage_bus_controller.sv
// ---------------------------------------------------------------------------
// memory_stage_bus_controller
//
// Performs the data-memory access for the instruction sitting in the memory
// stage. It turns load/store requests into a waitrequest-style bus
// transaction, builds big-endian byte lanes and replicated store data, and
// sign/zero-extends load data. It stalls the pipeline until the bus
// completes, and it flags misaligned accesses and bus timeouts.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   memory_to_register_memory  load request
//   memory_to_write_memory     store request (wins over load)
//   mem_size_memory            00 byte, 01 half, 1x word
//   mem_unsigned_memory        1 = zero-extend load result
//   ALU_output_memory          effective byte address
//   write_data_memory          right-justified store data
//   bus_address                word-aligned bus address
//   bus_read / bus_write       registered access strobes
//   bus_byteenable             big-endian lane enables (bit3 = data[31:24])
//   bus_writedata              store data replicated into lanes
//   bus_waitrequest            slave busy, hold request stable
//   bus_readdata               read data, valid when waitrequest = 0
//   read_data_memory           extended load result, valid in DONE
//   stall_memory               freezes the fetch..memory stages
//   address_error_memory       combinational pulse, misaligned request
//   bus_error_memory           one-cycle pulse, access exceeded MAX_WAIT
// ---------------------------------------------------------------------------
module memory_stage_bus_controller #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memory_to_register_memory,
   input  logic        memory_to_write_memory,
   input  logic [1:0]  mem_size_memory,
   input  logic        mem_unsigned_memory,
   input  logic [31:0] ALU_output_memory,
   input  logic [31:0] write_data_memory,
   output logic [31:0] bus_address,
   output logic        bus_read,
   output logic        bus_write,
   output logic [3:0]  bus_byteenable,
   output logic [31:0] bus_writedata,
   input  logic        bus_waitrequest,
   input  logic [31:0] bus_readdata,
   output logic [31:0] read_data_memory,
   output logic        stall_memory,
   output logic        address_error_memory,
   output logic        bus_error_memory
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [31:0]    addr_q, addr_d;
   logic           read_q, read_d;
   logic           write_q, write_d;
   logic [3:0]     be_q, be_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           berr_q, berr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     size_q, size_d;
   logic           uns_q, uns_d;
   logic [1:0]     lane_q, lane_d;

   // Request decode
   logic        request;
   logic        req_load;
   logic        misaligned;
   logic        accept;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;

   assign request  = memory_to_register_memory | memory_to_write_memory;
   assign req_load = memory_to_register_memory & ~memory_to_write_memory;

   always_comb begin
      misaligned = 1'b0;
      req_be     = 4'b1111;
      req_wdata  = write_data_memory;
      case (mem_size_memory)
         2'b00: begin
            req_be    = 4'b1000 >> ALU_output_memory[1:0];
            req_wdata = {4{write_data_memory[7:0]}};
         end
         2'b01: begin
            misaligned = ALU_output_memory[0];
            req_be     = ALU_output_memory[1] ? 4'b0011 : 4'b1100;
            req_wdata  = {2{write_data_memory[15:0]}};
         end
         default: begin
            misaligned = |ALU_output_memory[1:0];
         end
      endcase
   end

   // Reset gates the combinational outputs so a reset in the middle of an
   // access releases the pipeline in the same cycle.
   assign accept               = ~reset & (state_q == S_IDLE) & request & ~misaligned;
   assign address_error_memory = ~reset & (state_q == S_IDLE) & request & misaligned;
   assign stall_memory         = accept | (~reset & (state_q == S_ACCESS));

   // Load extraction uses the lane/size captured at request time, since the
   // address presented on the bus is word aligned.
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_ext;

   always_comb begin
      rd_byte = bus_readdata[7:0];
      case (lane_q)
         2'd0:    rd_byte = bus_readdata[31:24];
         2'd1:    rd_byte = bus_readdata[23:16];
         2'd2:    rd_byte = bus_readdata[15:8];
         default: rd_byte = bus_readdata[7:0];
      endcase
   end

   assign rd_half = lane_q[1] ? bus_readdata[15:0] : bus_readdata[31:16];

   always_comb begin
      load_ext = bus_readdata;
      case (size_q)
         2'b00:   load_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
         2'b01:   load_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
         default: load_ext = bus_readdata;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      read_d  = read_q;
      write_d = write_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      berr_d  = 1'b0;
      cnt_d   = cnt_q;
      size_d  = size_q;
      uns_d   = uns_q;
      lane_d  = lane_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d  = {ALU_output_memory[31:2], 2'b00};
               read_d  = req_load;
               write_d = memory_to_write_memory;
               be_d    = req_be;
               wdata_d = req_wdata;
               size_d  = mem_size_memory;
               uns_d   = mem_unsigned_memory;
               lane_d  = ALU_output_memory[1:0];
               cnt_d   = '0;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (!bus_waitrequest) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               if (read_q) begin
                  rdata_d = load_ext;
               end
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               // This wait cycle is the MAX_WAIT-th one: give up.
               if (cnt_q == WAIT_LAST) begin
                  read_d  = 1'b0;
                  write_d = 1'b0;
                  berr_d  = 1'b1;
                  rdata_d = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // Request inputs still belong to the finished instruction here.
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         berr_q  <= 1'b0;
         cnt_q   <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         read_q  <= read_d;
         write_q <= write_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         berr_q  <= berr_d;
         cnt_q   <= cnt_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         lane_q  <= lane_d;
      end
   end

   assign bus_address      = addr_q;
   assign bus_read         = read_q;
   assign bus_write        = write_q;
   assign bus_byteenable   = be_q;
   assign bus_writedata    = wdata_q;
   assign read_data_memory = rdata_q;
   assign bus_error_memory = berr_q;

endmodule
